// File: rtl/fht_pkg.sv
// Shared definitions for the FHT frame loader and its address generator:
// FSM state encoding, bank/address helpers and input sample conversion.
package fht_pkg;

  typedef logic [2:0] fht_state_t;

  localparam fht_state_t ST_LOAD     = 3'd0;
  localparam fht_state_t ST_GAP      = 3'd1;
  localparam fht_state_t ST_KICK     = 3'd2;
  localparam fht_state_t ST_HOLD     = 3'd3;
  localparam fht_state_t ST_WAIT_RDY = 3'd4;

  // Bank address width: each of the four banks holds N/4 points.
  function automatic int fht_a_bit(input int n);
    return $clog2(n) - 2;
  endfunction

  // The FHT core expects the frame quarters in 2-bit bit-reversed bank order.
  function automatic logic [1:0] fht_bank_rev(input logic [1:0] b);
    return {b[0], b[1]};
  endfunction

  // Converts a w-bit sample to a sign-extended 32-bit value. Offset-binary
  // input is turned into two's complement by inverting its MSB first.
  function automatic logic [31:0] fht_conv(input logic [31:0] x, input int w,
                                           input logic in_signed);
    logic [31:0] r;
    logic        msb;
    msb = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == w - 1) msb = x[i] ^ ~in_signed;
    end
    for (int i = 0; i < 32; i++) begin
      r[i] = (i < w - 1) ? x[i] : msb;
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_loader_addr_gen.sv
// Maps a linear sample index within the frame to a one-hot bank write enable
// and the address inside that bank. Purely combinational so readout logic can
// reuse it with its own counter.
module fht_loader_addr_gen
  import fht_pkg::*;
#(
  parameter  int N     = 1024,
  localparam int L     = $clog2(N),
  localparam int A_BIT = fht_a_bit(N)
) (
  input  logic [L-1:0]     n,
  output logic [3:0]       bank_we,
  output logic [A_BIT-1:0] addr
);

  logic [1:0] bank;

  // Top two index bits select the quarter, low bits address within it.
  always_comb begin
    bank    = fht_bank_rev(n[L-1 -: 2]);
    bank_we = 4'b0001 << bank;
    addr    = n[A_BIT-1:0];
  end

endmodule

// File: rtl/fht_frame_loader.sv
// Streams input samples into the four FHT RAM banks, then starts the FHT
// core after a quiet gap and waits for it to finish before loading the next
// frame. Samples arriving while not loading are dropped and flagged.
module fht_frame_loader
  import fht_pkg::*;
#(
  parameter  int N         = 1024,
  parameter  int D_BIT     = 16,
  parameter  int IN_SIGNED = 1,
  parameter  int START_GAP = 10,
  localparam int A_BIT     = fht_a_bit(N)
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iVALID,
  input  logic [D_BIT-2:0] iDATA,
  output logic             oREADY,
  output logic [D_BIT-1:0] oDATA,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [3:0]       oWE,
  input  logic             iFHT_RDY,
  output logic             oFHT_START,
  output logic             oFRAME_DONE,
  output logic             oOVERFLOW,
  input  logic             iCLR_OVF
);

  localparam int         L        = $clog2(N);
  localparam logic [7:0] GAP_LAST = 8'(START_GAP);

  fht_state_t       state;
  logic [L-1:0]     n_cnt;
  logic [7:0]       gap_cnt;
  logic             hold_cnt;
  logic             start_p1;
  logic             done_p1;
  logic             ovf;

  logic             ready;
  logic             vld_p0;
  logic [3:0]       bank_we_p0;
  logic [A_BIT-1:0] addr_p0;
  logic [D_BIT-1:0] data_p0;

  logic [3:0]       we_p1;
  logic [A_BIT-1:0] addr_p1;
  logic [D_BIT-1:0] data_p1;

  assign ready   = (state == ST_LOAD);
  assign vld_p0  = iVALID & ready;
  assign data_p0 = D_BIT'(fht_conv(32'(iDATA), D_BIT - 1, (IN_SIGNED != 0)));

  fht_loader_addr_gen #(.N(N)) u_addr_gen (
    .n       (n_cnt),
    .bank_we (bank_we_p0),
    .addr    (addr_p0)
  );

  // Frame sequencing: load N samples, quiet gap, start pulse, hold, wait.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state    <= ST_LOAD;
      n_cnt    <= '0;
      gap_cnt  <= '0;
      hold_cnt <= 1'b0;
      start_p1 <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      start_p1 <= 1'b0;
      done_p1  <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (vld_p0) begin
            n_cnt <= n_cnt + L'(1);
            if (&n_cnt) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end
        end
        // The first GAP cycle is the final write cycle itself, so the start
        // pulse lands START_GAP idle cycles after the last write.
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= ST_KICK;
            start_p1 <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        ST_KICK: begin
          state    <= ST_HOLD;
          hold_cnt <= 1'b0;
        end
        // The core's ready may still be high from the previous frame.
        ST_HOLD: begin
          if (hold_cnt) state <= ST_WAIT_RDY;
          else          hold_cnt <= 1'b1;
        end
        ST_WAIT_RDY: begin
          if (iFHT_RDY) begin
            state   <= ST_LOAD;
            done_p1 <= 1'b1;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Sticky overflow: a new drop takes priority over a clear request.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET)                ovf <= 1'b0;
    else if (iVALID && !ready) ovf <= 1'b1;
    else if (iCLR_OVF)         ovf <= 1'b0;
  end

  // ---- stage p0 -> p1: registered RAM write port ----
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      we_p1   <= 4'b0000;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      we_p1 <= vld_p0 ? bank_we_p0 : 4'b0000;
      if (vld_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign oREADY      = ready;
  assign oWE         = we_p1;
  assign oADDR_WR    = addr_p1;
  assign oDATA       = data_p1;
  assign oFHT_START  = start_p1;
  assign oFRAME_DONE = done_p1;
  assign oOVERFLOW   = ovf;

endmodule

// File: tb/tb_fht_frame_loader.sv
// Directed bench for fht_frame_loader: a N=1024 two's-complement instance
// and a N=16 offset-binary instance sharing one clock.
module tb_fht_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: N=1024, signed input, START_GAP=10
  logic        a_rst, a_valid, a_fht_rdy, a_clr;
  logic [14:0] a_din;
  logic        a_ready, a_start, a_done, a_ovf;
  logic [15:0] a_dout;
  logic [7:0]  a_addr;
  logic [3:0]  a_we;

  fht_frame_loader #(.N(1024), .D_BIT(16), .IN_SIGNED(1), .START_GAP(10)) dut_a (
    .iCLK(clk), .iRESET(a_rst), .iVALID(a_valid), .iDATA(a_din),
    .oREADY(a_ready), .oDATA(a_dout), .oADDR_WR(a_addr), .oWE(a_we),
    .iFHT_RDY(a_fht_rdy), .oFHT_START(a_start), .oFRAME_DONE(a_done),
    .oOVERFLOW(a_ovf), .iCLR_OVF(a_clr)
  );

  // Instance B: N=16, offset-binary input, START_GAP=3
  logic        b_rst, b_valid, b_fht_rdy, b_clr;
  logic [14:0] b_din;
  logic        b_ready, b_start, b_done, b_ovf;
  logic [15:0] b_dout;
  logic [1:0]  b_addr;
  logic [3:0]  b_we;

  fht_frame_loader #(.N(16), .D_BIT(16), .IN_SIGNED(0), .START_GAP(3)) dut_b (
    .iCLK(clk), .iRESET(b_rst), .iVALID(b_valid), .iDATA(b_din),
    .oREADY(b_ready), .oDATA(b_dout), .oADDR_WR(b_addr), .oWE(b_we),
    .iFHT_RDY(b_fht_rdy), .oFHT_START(b_start), .oFRAME_DONE(b_done),
    .oOVERFLOW(b_ovf), .iCLR_OVF(b_clr)
  );

  // Frame quarter q lands in bank {q[0],q[1]}: 0->0, 1->2, 2->1, 3->3
  logic [3:0] we_tab [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Streams count samples continuously into A; sample 0 uses d0/e0, sample i>0 is i.
  task automatic a_ramp(input int count, input logic [14:0] d0, input logic [15:0] e0);
    for (int i = 0; i < count; i++) begin
      chk($sformatf("a_ready_load[%0d]", i), 32'(a_ready), 32'd1);
      a_valid = 1'b1;
      a_din   = (i == 0) ? d0 : 15'(i);
      @(negedge clk);
      chk($sformatf("a_we[%0d]", i), 32'(a_we), 32'(we_tab[i / 256]));
      chk($sformatf("a_addr[%0d]", i), 32'(a_addr), 32'(i % 256));
      chk($sformatf("a_data[%0d]", i), 32'(a_dout), (i == 0) ? 32'(e0) : 32'(i));
    end
    a_valid = 1'b0;
  endtask

  // Called at the negedge of the last write cycle of a full frame on A.
  task automatic a_tail(input bit inject_ovf);
    chk("a_ready_gap", 32'(a_ready), 32'd0);
    a_fht_rdy = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("a_start_early[%0d]", c), 32'(a_start), 32'd0);
      chk($sformatf("a_we_gap[%0d]", c), 32'(a_we), 32'd0);
    end
    @(negedge clk);
    chk("a_start_pulse", 32'(a_start), 32'd1);
    chk("a_ready_kick", 32'(a_ready), 32'd0);
    @(negedge clk);
    chk("a_start_once", 32'(a_start), 32'd0);
    chk("a_done_hold0", 32'(a_done), 32'd0);
    @(negedge clk);
    chk("a_done_hold1", 32'(a_done), 32'd0);
    @(negedge clk);
    chk("a_done_wait0", 32'(a_done), 32'd0);
    a_fht_rdy = 1'b0;
    for (int c = 1; c <= 49; c++) begin
      if (c == 1) chk("a_ovf_before", 32'(a_ovf), 32'd0);
      a_valid = inject_ovf && (c >= 10) && (c <= 14);
      a_din   = 15'h1234;
      @(negedge clk);
      chk($sformatf("a_done_wait[%0d]", c), 32'(a_done), 32'd0);
      chk($sformatf("a_ready_wait[%0d]", c), 32'(a_ready), 32'd0);
      chk($sformatf("a_we_wait[%0d]", c), 32'(a_we), 32'd0);
    end
    a_valid = 1'b0;
    chk("a_ovf_wait", 32'(a_ovf), 32'(inject_ovf));
    a_fht_rdy = 1'b1;
    @(negedge clk);
    chk("a_done_pulse", 32'(a_done), 32'd1);
    chk("a_ready_after_done", 32'(a_ready), 32'd1);
    a_fht_rdy = 1'b0;
    @(negedge clk);
    chk("a_done_once", 32'(a_done), 32'd0);
    chk("a_ovf_sticky", 32'(a_ovf), 32'(inject_ovf));
  endtask

  initial begin
    logic [14:0] b_in  [16];
    logic [15:0] b_exp [16];
    b_in[0] = 15'h0000; b_exp[0] = 16'hC000;
    b_in[1] = 15'h7FFF; b_exp[1] = 16'h3FFF;
    b_in[2] = 15'h4000; b_exp[2] = 16'h0000;
    b_in[3] = 15'h3FFF; b_exp[3] = 16'hFFFF;
    for (int i = 4; i < 16; i++) begin
      b_in[i]  = 15'(i);
      b_exp[i] = 16'hC000 | 16'(i);
    end

    a_rst = 1'b1; a_valid = 1'b0; a_fht_rdy = 1'b0; a_clr = 1'b0; a_din = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_fht_rdy = 1'b0; b_clr = 1'b0; b_din = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_a_we", 32'(a_we), 32'd0);
    chk("rst_a_addr", 32'(a_addr), 32'd0);
    chk("rst_a_data", 32'(a_dout), 32'd0);
    chk("rst_a_start", 32'(a_start), 32'd0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_ovf", 32'(a_ovf), 32'd0);
    chk("rst_b_we", 32'(b_we), 32'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);

    // Frame 1: full ramp, then overflow injected while waiting for the core
    a_ramp(1024, 15'd0, 16'd0);
    a_tail(1'b1);

    // Frame 2: starts at bank0 addr0, signed 0x4000 -> 0xC000, reset after sample 300
    a_ramp(301, 15'h4000, 16'hC000);
    chk("a_ovf_mid_frame", 32'(a_ovf), 32'd1);
    #2 a_rst = 1'b1;
    #1;
    chk("arst_we", 32'(a_we), 32'd0);
    chk("arst_addr", 32'(a_addr), 32'd0);
    chk("arst_data", 32'(a_dout), 32'd0);
    chk("arst_ovf", 32'(a_ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);

    // Frame 3: partial frame discarded, full frame loads from the start
    a_ramp(1024, 15'd0, 16'd0);
    a_tail(1'b0);

    // Instance B: one valid every three cycles
    for (int i = 0; i < 16; i++) begin
      b_valid = 1'b1;
      b_din   = b_in[i];
      @(negedge clk);
      chk($sformatf("b_we[%0d]", i), 32'(b_we), 32'(we_tab[i / 4]));
      chk($sformatf("b_addr[%0d]", i), 32'(b_addr), 32'(i % 4));
      chk($sformatf("b_data[%0d]", i), 32'(b_dout), 32'(b_exp[i]));
      if (i != 15) begin
        b_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("b_we_idle1[%0d]", i), 32'(b_we), 32'd0);
        @(negedge clk);
        chk($sformatf("b_we_idle2[%0d]", i), 32'(b_we), 32'd0);
      end
    end
    // Drop during GAP together with a clear: the set must win
    b_valid = 1'b1;
    b_clr   = 1'b1;
    @(negedge clk);
    chk("b_ovf_set_wins", 32'(b_ovf), 32'd1);
    chk("b_we_dropped", 32'(b_we), 32'd0);
    chk("b_start_g1", 32'(b_start), 32'd0);
    b_valid = 1'b0;
    @(negedge clk);
    chk("b_ovf_cleared", 32'(b_ovf), 32'd0);
    chk("b_start_g2", 32'(b_start), 32'd0);
    b_clr = 1'b0;
    @(negedge clk);
    chk("b_start_g3", 32'(b_start), 32'd0);
    @(negedge clk);
    chk("b_start_pulse", 32'(b_start), 32'd1);
    @(negedge clk);
    chk("b_start_once", 32'(b_start), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b_done_wait0", 32'(b_done), 32'd0);
    chk("b_ready_wait", 32'(b_ready), 32'd0);
    b_fht_rdy = 1'b1;
    @(negedge clk);
    chk("b_done_pulse", 32'(b_done), 32'd1);
    chk("b_ready_after_done", 32'(b_ready), 32'd1);
    b_fht_rdy = 1'b0;
    @(negedge clk);
    chk("b_done_once", 32'(b_done), 32'd0);
    chk("b_start_none", 32'(b_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
